prbs4_checker: RTL and testbench

PRBS4_CHECKER -- requirements
Module: prbs4_checker

---
 rtl/prbs_pkg.sv | 6 +
 rtl/prbs4_checker_if.sv | 12 +
 rtl/prbs4_predict.sv | 9 +
 rtl/prbs4_checker.sv | 90 +++++++++
 tb/tb_prbs4_checker.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS-4 state type, tap mask and seed for checker and future generator
package prbs_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;
  localparam logic [3:0] PRBS4_TAPS = 4'b1100;
  localparam logic [3:0] PRBS4_SEED = 4'b0001;
endpackage

// File: rtl/prbs4_checker_if.sv
// prbs4_checker_if: serial bit input and lock/error status of the PRBS-4 checker
interface prbs4_checker_if;
  logic        en;
  logic        din;
  logic        clr_cnt;
  logic        locked;
  logic        err;
  logic [15:0] err_count;
  logic [1:0]  state;
  modport master (output en, din, clr_cnt, input locked, err, err_count, state);
  modport slave  (input en, din, clr_cnt, output locked, err, err_count, state);
endinterface

// File: rtl/prbs4_predict.sv
// prbs4_predict: next PRBS-4 bit from a 4-bit history (h[0] newest)
module prbs4_predict
  import prbs_pkg::*;
(
  input  logic [3:0] i_h,
  output logic       o_p
);
  assign o_p = ^(i_h & PRBS4_TAPS);
endmodule

// File: rtl/prbs4_checker.sv
// prbs4_checker: PRBS-4 (x^4+x^3+1) lock acquisition, flywheel error checking and windowed loss-of-lock
module prbs4_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_ERR = 4,
  parameter int WINDOW     = 16
) (
  input logic clk,
  input logic rst,
  prbs4_checker_if.slave bus
);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = WW + 1;
  state_t        r_state;
  logic [3:0]    r_h;
  logic [1:0]    r_fill;
  logic [3:0]    r_match;
  logic [WW-1:0] r_win_bit;
  logic [EW-1:0] r_win_err;
  logic          r_err;
  logic [15:0]   r_err_count;
  logic          w_p, w_mis, w_lerr, w_wrap, w_unlock, w_lock_hit;
  logic [3:0]    w_h_din, w_m_inc;
  logic [EW-1:0] w_win_err;
  prbs4_predict u_pred (.i_h(r_h), .o_p(w_p));
  assign w_mis      = bus.din ^ w_p;
  assign w_h_din    = {r_h[2:0], bus.din};
  assign w_lerr     = bus.en && r_state == LOCKED && w_mis;
  assign w_win_err  = r_win_err + EW'(w_lerr);
  assign w_unlock   = w_win_err >= EW'(UNLOCK_ERR);
  assign w_wrap     = r_win_bit == WW'(WINDOW - 1);
  assign w_m_inc    = r_match + 4'd1;
  assign w_lock_hit = !w_mis && w_m_inc == 4'(LOCK_CNT) && w_h_din != 4'd0;
  assign bus.locked    = r_state == LOCKED;
  assign bus.err       = r_err;
  assign bus.err_count = r_err_count;
  assign bus.state     = r_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_h         <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win_bit   <= '0;
      r_win_err   <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err <= w_lerr;
      if (bus.clr_cnt) r_err_count <= {15'd0, w_lerr};
      else if (w_lerr && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      if (bus.en) begin
        case (r_state)
          HUNT: begin
            r_h    <= w_h_din;
            r_fill <= r_fill + 2'd1;
            if (r_fill == 2'd3) begin
              r_state <= VERIFY;
              r_match <= '0;
            end
          end
          VERIFY: begin
            r_h     <= w_h_din;
            r_match <= (w_mis || w_h_din == 4'd0) ? 4'd0 : w_m_inc;
            if (w_lock_hit) begin
              r_state   <= LOCKED;
              r_match   <= '0;
              r_win_bit <= '0;
              r_win_err <= '0;
            end
          end
          LOCKED: begin
            // flywheel: the prediction, not the received bit, feeds the history
            r_h       <= {r_h[2:0], w_p};
            r_win_bit <= r_win_bit + WW'(1);
            r_win_err <= w_wrap ? '0 : w_win_err;
            if (w_unlock) begin
              r_state   <= HUNT;
              r_fill    <= '0;
              r_win_bit <= '0;
              r_win_err <= '0;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prbs4_checker.sv
// tb_prbs4_checker: directed and randomized checks of prbs4_checker against a bit-queue reference model
module tb_prbs4_checker;
  localparam int LC = 8, UE = 4, W = 16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  prbs4_checker_if ifa ();
  prbs4_checker_if ifb ();
  prbs4_checker #(.LOCK_CNT(LC), .UNLOCK_ERR(UE), .WINDOW(W)) dut (.clk(clk), .rst(rst), .bus(ifa));
  prbs4_checker #(.LOCK_CNT(8), .UNLOCK_ERR(256), .WINDOW(256)) dut_sat (.clk(clk), .rst(rst), .bus(ifb));
  int n_cmp = 0, n_bad = 0;
  logic [14:0] pat = 15'b000100110101111;
  int spos = 0;
  int m_st, m_fill, m_match, m_wpos, m_werr, m_cnt;
  bit m_err;
  bit hist[$];
  function automatic bit sbit(input int k);
    return pat[14 - (k % 15)];
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    assert (got === exp_v) else begin
      n_bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp_v);
    end
  endtask
  task automatic mreset();
    m_st = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_cnt = 0; m_err = 0;
    hist = '{0, 0, 0, 0};
  endtask
  task automatic push(input bit b);
    hist.push_back(b);
    void'(hist.pop_front());
  endtask
  // hist[0] is the bit received four enabled bits ago, hist[1] three ago
  task automatic mstep(input bit e, input bit d, input bit c);
    bit p;
    m_err = 0;
    if (c) m_cnt = 0;
    if (!e) return;
    p = hist[0] ^ hist[1];
    if (m_st == 0) begin
      push(d);
      m_fill++;
      if (m_fill == 4) begin m_st = 1; m_fill = 0; m_match = 0; end
    end else if (m_st == 1) begin
      push(d);
      m_match = (d == p) ? m_match + 1 : 0;
      if ((hist[0] | hist[1] | hist[2] | hist[3]) == 0) m_match = 0;
      if (m_match == LC) begin m_st = 2; m_wpos = 0; m_werr = 0; m_match = 0; end
    end else begin
      if (d != p) begin
        m_err = 1;
        if (m_cnt < 65535) m_cnt++;
        m_werr++;
      end
      push(p);
      if (m_werr >= UE) begin m_st = 0; m_fill = 0; end
      else if (m_wpos == W - 1) m_werr = 0;
      m_wpos = (m_wpos + 1) % W;
    end
  endtask
  task automatic tick(input string tag, input bit e, input bit d, input bit c);
    ifa.en = e; ifa.din = d; ifa.clr_cnt = c;
    @(posedge clk);
    if (rst) mreset(); else mstep(e, d, c);
    @(negedge clk);
    chk({tag, ":state"}, 32'(ifa.state), m_st);
    chk({tag, ":locked"}, 32'(ifa.locked), 32'(m_st == 2));
    chk({tag, ":err"}, 32'(ifa.err), 32'(m_err));
    chk({tag, ":err_count"}, 32'(ifa.err_count), m_cnt);
  endtask
  task automatic satbit(input bit d, input bit c);
    ifb.en = 1'b1; ifb.din = d; ifb.clr_cnt = c;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    bit e, d, inv, seen;
    int nerr;
    mreset();
    ifb.en = 1'b0; ifb.din = 1'b0; ifb.clr_cnt = 1'b0;
    rst = 1'b1;
    tick("reset", 1, 1, 1);
    tick("reset", 1, 1, 1);
    rst = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick("clean", 1, sbit(spos), 0); spos++;
      if (k == 10) chk("pre_lock", 32'(ifa.locked), 0);
      if (k == 11) chk("lock12", 32'(ifa.locked), 1);
    end
    chk("clean_cnt", 32'(ifa.err_count), 0);
    tick("one_inv", 1, ~sbit(spos), 0); spos++;
    chk("one_err_pulse", 32'(ifa.err), 1);
    for (int k = 0; k < 100; k++) begin tick("after_one", 1, sbit(spos), 0); spos++; end
    chk("one_cnt", 32'(ifa.err_count), 1);
    chk("one_locked", 32'(ifa.locked), 1);
    while (m_wpos != 0) begin tick("align", 1, sbit(spos), 0); spos++; end
    for (int i = 0; i < 7; i++) begin
      tick("burst", 1, sbit(spos) ^ (i % 2 == 0), 0); spos++;
    end
    chk("burst_unlock", 32'(ifa.locked), 0);
    chk("burst_hunt", 32'(ifa.state), 0);
    for (int k = 0; k < 12; k++) begin
      if (k == 11) chk("relock_pre", 32'(ifa.locked), 0);
      tick("relock", 1, sbit(spos), 0); spos++;
    end
    chk("relock12", 32'(ifa.locked), 1);
    tick("clr_err", 1, ~sbit(spos), 1); spos++;
    chk("clr_with_err", 32'(ifa.err_count), 1);
    tick("clr_only", 1, sbit(spos), 1); spos++;
    chk("clr_alone", 32'(ifa.err_count), 0);
    tick("pre_rst_err", 1, ~sbit(spos), 0); spos++;
    rst = 1'b1;
    tick("rst_mid", 1, ~sbit(spos), 1); spos++;
    rst = 1'b0;
    chk("rst_locked", 32'(ifa.locked), 0);
    chk("rst_err", 32'(ifa.err), 0);
    chk("rst_cnt", 32'(ifa.err_count), 0);
    chk("rst_state", 32'(ifa.state), 0);
    for (int k = 0; k < 50; k++) tick("zeros", 1, 0, 0);
    chk("zeros_state", 32'(ifa.state), 1);
    chk("zeros_cnt", 32'(ifa.err_count), 0);
    rst = 1'b1;
    tick("rst2", 0, 0, 0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 800; k++) begin
      e = $urandom_range(0, 9) < 3;
      tick("duty30", e, sbit(spos), 0);
      if (e) spos++;
      if (ifa.locked) seen = 1;
    end
    chk("duty30_locked", 32'(seen), 1);
    for (int k = 0; k < 3000; k++) begin
      e = $urandom_range(0, 9) < 7;
      inv = $urandom_range(0, 29) == 0;
      tick("rand_err", e, sbit(spos) ^ inv, $urandom_range(0, 199) == 0);
      if (e) spos++;
    end
    ifa.en = 1'b0; ifa.clr_cnt = 1'b0;
    for (int k = 0; k < 12; k++) satbit(sbit(k), 0);
    chk("sat_lock", 32'(ifb.locked), 1);
    nerr = 0;
    for (int j = 0; nerr < 66000; j++) begin
      inv = (j % 256) != 255;
      satbit(sbit(12 + j) ^ inv, 0);
      if (inv) nerr++;
      if (inv && nerr == 65534) chk("sat_fffe", 32'(ifb.err_count), 65534);
    end
    chk("sat_ffff", 32'(ifb.err_count), 32'hFFFF);
    chk("sat_still_locked", 32'(ifb.locked), 1);
    satbit(~sbit(12 + 66000 + 258), 1);
    chk("sat_clr_with_err", 32'(ifb.err_count), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
